// File: rtl/bidir_shift_sequencer.sv
// Feeds a WIDTH-bit word into a free-running bidirectional shift register,
// one serial bit per clock, with a valid/ready front end and a done pulse.
module bidir_shift_sequencer #(
   parameter int   WIDTH = 4,
   parameter logic FILL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   output logic             mode,
   output logic             dr,
   output logic             dl,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LEFT_BASE = CNT_W'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH-1:0]   word, word_nxt;
   logic               dir, dir_nxt;
   logic               mode_nxt, dr_nxt, dl_nxt, busy_nxt, done_nxt;
   logic               accept;
   logic [CNT_W-1:0]   cnt_inc;
   logic [CNT_W-1:0]   left_idx;

   assign in_ready = rst && (state != SHIFT);
   assign accept   = in_valid && in_ready;
   assign cnt_inc  = cnt + 1'b1;
   // Index of the next bit for a left load; only used while cnt < WIDTH-1.
   assign left_idx = LEFT_BASE - cnt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      word_nxt  = word;
      dir_nxt   = dir;
      mode_nxt  = mode;
      dr_nxt    = FILL;
      dl_nxt    = FILL;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               word_nxt  = in_data;
               dir_nxt   = in_dir;
               mode_nxt  = in_dir;
               busy_nxt  = 1'b1;
               // Bit 0 of the stream is presented straight from the input so
               // it appears in the cycle right after acceptance.
               if (in_dir) dr_nxt = in_data[0];
               else        dl_nxt = in_data[WIDTH-1];
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            cnt_nxt = cnt_inc;
            if (cnt == LAST) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               busy_nxt = 1'b1;
               if (dir) dr_nxt = word[cnt_inc];
               else     dl_nxt = word[left_idx];
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         word  <= '0;
         dir   <= 1'b0;
         mode  <= 1'b0;
         dr    <= FILL;
         dl    <= FILL;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         word  <= word_nxt;
         dir   <= dir_nxt;
         mode  <= mode_nxt;
         dr    <= dr_nxt;
         dl    <= dl_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_bidir_shift_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit bidirectional shift
// register; serial streams and register contents checked against hand values.
module tb_bidir_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_dir;
   logic       mode, dr, dl, busy, done;
   logic [3:0] q = '0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         done_cyc;
   int         prev_done_cyc;

   always #5 clk = ~clk;

   bidir_shift_sequencer #(.WIDTH(4), .FILL(1'b0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dir(in_dir), .mode(mode), .dr(dr), .dl(dl),
      .busy(busy), .done(done)
   );

   // Downstream register: no enable, shifts every clock.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mode) q <= {dr, q[3:1]};
      else      q <= {q[2:0], dl};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word must already be offered so the next edge accepts it. seq[k] is the
   // expected serial bit in the cycle after edge Ek. Returns in the DONE cycle
   // with in_valid dropped.
   task automatic run_word(input string name, input logic dirv, input logic [3:0] seq,
                           input logic [3:0] exp_q, input logic scramble);
      tick();
      in_valid = scramble;
      for (int k = 0; k < 4; k++) begin
         if (scramble) begin
            in_data = 4'($urandom);
            in_dir  = 1'($urandom);
         end
         check({name, " mode"}, mode, dirv);
         check({name, " dr"}, dr, dirv ? seq[k] : 1'b0);
         check({name, " dl"}, dl, dirv ? 1'b0 : seq[k]);
         check({name, " busy"}, busy, 1'b1);
         check({name, " done low"}, done, 1'b0);
         check({name, " in_ready low"}, in_ready, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      done_cyc = cyc;
      check({name, " done"}, done, 1'b1);
      check({name, " busy in done"}, busy, 1'b0);
      check({name, " dr fill"}, dr, 1'b0);
      check({name, " dl fill"}, dl, 1'b0);
      check({name, " mode hold"}, mode, dirv);
      check({name, " q"}, q, exp_q);
      check({name, " in_ready done"}, in_ready, 1'b1);
   endtask

   task automatic offer(input logic [3:0] d, input logic dirv);
      in_valid = 1'b1;
      in_data  = d;
      in_dir   = dirv;
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'b1111;
      in_dir   = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst in_ready", in_ready, 1'b0);
         check("rst mode", mode, 1'b0);
         check("rst dr", dr, 1'b0);
         check("rst dl", dl, 1'b0);
         check("rst busy", busy, 1'b0);
         check("rst done", done, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("post-rst in_ready", in_ready, 1'b1);
      check("post-rst busy", busy, 1'b0);
      tick();
      check("idle busy", busy, 1'b0);

      // Right load 1011: dr stream 1,1,0,1
      offer(4'b1011, 1'b1);
      run_word("right", 1'b1, 4'b1011, 4'b1011, 1'b0);
      tick();
      check("idle after right done", done, 1'b0);
      check("idle mode hold", mode, 1'b1);

      // Left load 0110: dl stream 0,1,1,0
      offer(4'b0110, 1'b0);
      run_word("left", 1'b0, 4'b0110, 4'b0110, 1'b0);
      tick();

      // Back-to-back: second word offered in the DONE cycle
      offer(4'b1011, 1'b1);
      run_word("b2b1", 1'b1, 4'b1011, 4'b1011, 1'b0);
      prev_done_cyc = done_cyc;
      offer(4'b0110, 1'b0);
      run_word("b2b2", 1'b0, 4'b0110, 4'b0110, 1'b0);
      check("b2b done spacing", done_cyc - prev_done_cyc, 5);
      tick();
      check("b2b idle", busy, 1'b0);

      // Mid-operation reset after two bits of 1111
      offer(4'b1111, 1'b1);
      tick();
      in_valid = 1'b0;
      check("mid bit0 dr", dr, 1'b1);
      tick();
      check("mid bit1 dr", dr, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("mid rst mode", mode, 1'b0);
      check("mid rst dr", dr, 1'b0);
      check("mid rst dl", dl, 1'b0);
      check("mid rst busy", busy, 1'b0);
      check("mid rst done", done, 1'b0);
      check("mid rst in_ready", in_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid rst no done", done, 1'b0);
         check("mid rst hold busy", busy, 1'b0);
      end
      rst = 1'b1;
      #1;
      check("mid release in_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid release no done", done, 1'b0);
      end
      offer(4'b0001, 1'b1);
      run_word("after rst", 1'b1, 4'b0001, 4'b0001, 1'b0);
      tick();

      // Stability: inputs toggled every SHIFT cycle; left 1100 -> dl 1,1,0,0
      offer(4'b1100, 1'b0);
      run_word("stable", 1'b0, 4'b0011, 4'b1100, 1'b1);
      tick();
      check("stable idle", busy, 1'b0);
      check("stable no accept", in_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
